product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
//   Downstream consumer of the sequential multiplier's 16-bit signed product.
//   Converts a two's-complement value to sign + DIGITS packed-BCD digits,
//   using sequential double-dabble (one bit per clock), for display/readout.
//   Fed by the multiplier's product and Ready strobe; drives the display/decoder stage.
// PARAMETERS
//   DATA_WIDTH  16  width of signed input (product width)
//   DIGITS      5   BCD digits out; must satisfy 10**DIGITS > 2**(DATA_WIDTH-1)
// PORTS
//   clk      in   1               single clock, rising edge
//   rst      in   1               synchronous, active-high reset
//   start    in   1               request; sampled high in IDLE/DONE -> capture data_in
//   data_in  in   DATA_WIDTH      signed two's-complement value (multiplier Producto)
//   busy     out  1               high while a conversion is in progress (CONV)
//   done     out  1               one-cycle pulse: sign/bcd valid and updated
//   sign     out  1               1 = input was negative
//   bcd      out  4*DIGITS        packed BCD magnitude, digit 0 in [3:0]
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE; busy=0, done=0, sign=0, bcd=0, counter=0.
//     Applies from any state, incl. mid-conversion; partial result discarded.
//   FSM: IDLE -> CONV on start=1; CONV -> DONE after DATA_WIDTH shift cycles;
//     DONE -> CONV if start=1, else IDLE. DONE lasts exactly one cycle.
//   Accept (edge N, state IDLE or DONE, start=1): sign_r <= data_in[MSB];
//     mag <= |data_in| as DATA_WIDTH-bit unsigned; scratch BCD <= 0; cnt <= 0.
//   CONV, each edge: every scratch digit >= 5 gets +3, then shift {bcd,mag}
//     left 1 (mag MSB into digit-0 LSB); cnt++. Edge N+DATA_WIDTH does last shift.
//   Edge N+DATA_WIDTH: bcd <= final scratch, sign <= sign_r, state=DONE.
//     done=1 during the cycle after that edge; latency DATA_WIDTH cycles
//     (16 at default) from accept edge to done.
//   busy = (state==CONV); done = (state==DONE); both decoded from registered state.
//   sign, bcd hold last converted value until next DONE (not cleared on accept).
//   start while CONV: ignored, no queuing, current conversion unaffected.
//   start held high: back-to-back conversions; new accept at the DONE edge,
//     data_in re-sampled then. start and done coincident = accepted.
//   Zero: sign=0 (no negative zero). Most-negative input -2**(DATA_WIDTH-1):
//     magnitude taken unsigned, no overflow; sign=1.
//   data_in only sampled at accept edge; changes during CONV have no effect.
// TESTING
//   1 rst, start pulse data_in=16'sd0 -> done after 16 clks, sign=0, bcd=20'h00000
//   2 data_in=-9017 (-127*71) -> sign=1, bcd=20'h09017, busy high exactly 16 clks
//   3 data_in=32767 -> sign=0, bcd=20'h32767; data_in=-32768 -> sign=1, bcd=20'h32768
//   4 start again 5 clks into conversion of 1234 with data_in=999 -> result 01234
//     only, single done pulse, no second conversion
//   5 rst at clk 8 of conversion of -500 -> busy=0,done=0,bcd=0,sign=0 next cycle;
//     no done pulse appears afterwards
//   6 start held high, data_in 42 then -7 at DONE -> done pulses 17 clks apart,
//     bcd 00042/sign 0 then 00007/sign 1

Source files
------------

// File: rtl/product_bcd_converter.sv
// product_bcd_converter
// Converts a signed two's-complement product into sign + packed BCD magnitude
// with a sequential double-dabble, one input bit per clock. The result is held
// on sign/bcd until the next conversion completes, and done pulses for one
// cycle when sign/bcd update.
module product_bcd_converter #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    sign,
  output logic [4*DIGITS-1:0]     bcd
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   mag;
  logic [4*DIGITS-1:0]     scratch;
  logic                    sign_r;

  logic [DATA_WIDTH-1:0]   abs_in;
  logic [4*DIGITS-1:0]     adjusted;
  logic [4*DIGITS-1:0]     shifted;

  // Magnitude of the input; the most-negative value maps to 2**(DATA_WIDTH-1)
  // because the result is read as unsigned.
  assign abs_in = data_in[DATA_WIDTH-1] ? -data_in : data_in;

  // Add 3 to every scratch digit that is 5 or more before the next shift.
  always_comb begin
    // NOTE: assign a full default before the loop so no path leaves adjusted
    // unassigned; a partially assigned combinational output infers a latch.
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the adjusted digits left, pulling the magnitude MSB into digit 0.
  assign shifted = {adjusted[4*DIGITS-2:0], mag[DATA_WIDTH-1]};

  // Conversion sequencer: accept in IDLE/DONE, shift DATA_WIDTH times in CONV,
  // publish the result on the last shift.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the values
    // present before the edge; mixing in = would make order inside the block matter.
    if (rst) begin
      // NOTE: the datapath registers are cleared along with the control state
      // so the block comes out of reset fully defined, not just the outputs.
      state   <= IDLE;
      cnt     <= '0;
      mag     <= '0;
      scratch <= '0;
      sign_r  <= 1'b0;
      sign    <= 1'b0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sign_r  <= data_in[DATA_WIDTH-1];
            mag     <= abs_in;
            scratch <= '0;
            cnt     <= '0;
            state   <= CONV;
          end else begin
            state   <= IDLE;
          end
        end
        CONV: begin
          scratch <= shifted;
          mag     <= mag << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            bcd   <= shifted;
            sign  <= sign_r;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CONV);
  assign done = (state == DONE);

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter
// Scoreboarded bench: the driver pushes the expected sign/BCD (computed with
// plain decimal arithmetic) at every accept; a monitor pops and compares on
// each done pulse, also checking latency and busy duration.
module tb_product_bcd_converter;

  localparam int DW  = 16;
  localparam int DG  = 5;
  localparam int LAT = DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   data_in;
  logic            busy;
  logic            done;
  logic            sign;
  logic [4*DG-1:0] bcd;

  typedef struct {
    logic            sign;
    logic [4*DG-1:0] bcd;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  product_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .sign    (sign),
    .bcd     (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: sign and decimal digits of the value, by division.
  function automatic exp_t ref_model(input logic signed [DW-1:0] v, input int acc);
    exp_t e;
    int   m;
    m = int'(v);
    e.sign = (m < 0);
    if (m < 0) m = -m;
    e.bcd = '0;
    for (int d = 0; d < DG; d++) begin
      e.bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.acc_cyc = acc;
    return e;
  endfunction

  // Monitor: compare every done pulse with the oldest expected result.
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        check("done_single_cycle", 32'(prev_done), 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("sign", 32'(sign), 32'(e.sign));
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("latency", 32'(cyc - e.acc_cyc), LAT);
          check("busy_cycles", 32'(busy_run), LAT);
        end
        busy_run = 0;
      end else if (!busy) begin
        busy_run = 0;
      end
      prev_done = done;
    end else begin
      busy_run  = 0;
      prev_done = 1'b0;
    end
  end

  // Present start for one accept edge and record the expectation.
  task automatic issue(input logic [DW-1:0] v, input bit expect_result);
    @(negedge clk);
    start   = 1'b1;
    data_in = v;
    @(posedge clk);
    #1;
    if (expect_result) sb.push_back(ref_model(v, cyc));
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    bit seen;
    seen = 0;
    t = -1;
    for (int i = 0; i < 3 * LAT && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        t = cyc;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected one within %0d cycles", 3 * LAT);
    end
  endtask

  int t1, t2;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sign", 32'(sign), 0);
    check("rst_bcd",  32'(bcd),  0);
    rst = 1'b0;

    // Zero, then a negative product, then both range extremes.
    issue(16'sd0, 1);       wait_done(t1);
    issue(-16'sd9017, 1);   wait_done(t1);
    issue(16'sd32767, 1);   wait_done(t1);
    issue(16'h8000, 1);     wait_done(t1);

    // start during CONV is ignored; data_in changes mid-conversion do nothing.
    issue(16'sd1234, 1);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    data_in = 16'sd999;
    @(negedge clk);
    start   = 1'b0;
    wait_done(t1);
    repeat (2 * LAT) @(negedge clk);

    // Reset in the middle of a conversion discards it.
    issue(-16'sd500, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_sign", 32'(sign), 0);
    check("midrst_bcd",  32'(bcd),  0);
    rst = 1'b0;
    repeat (2 * LAT) @(negedge clk);

    // start held high: re-accept at the DONE edge with new data.
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'sd42;
    @(posedge clk);
    #1;
    sb.push_back(ref_model(16'sd42, cyc));
    wait_done(t1);
    data_in = -16'sd7;
    @(posedge clk);
    #1;
    sb.push_back(ref_model(-16'sd7, cyc));
    start = 1'b0;
    wait_done(t2);
    check("b2b_spacing", 32'(t2 - t1), LAT + 1);

    // Random products.
    for (int i = 0; i < 40; i++) begin
      issue(DW'($urandom), 1);
      wait_done(t1);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "timeout");
  end

endmodule
